ofifo_align: RTL and testbench
==============================

# ofifo_align

Output-side column FIFO bank that sits directly south of the MAC array. It captures the partial sum leaving the bottom tile of each column whenever that column flags a valid result. Because the array skews execution, columns produce results on different cycles; the block re-aligns them so that one full row of `col` psums is presented to the consumer at once. Reads are first-word-fall-through, and a sticky error bit records any dropped write.

## Interface
- `col`, default 8: number of array columns, i.e. independent column FIFOs.
- `psum_bw`, default 16: psum width, equal to the tile `out_s` width.
- `depth`, default 16: entries per column FIFO. Must be a power of two and ≥ 2.
- `clk`  input  1: single clock. All state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low. 0 clears all state immediately, independent of `clk`.
- `wr`  input  col: per-column write strobe. Bit j is column j's valid flag from the array bottom.
- `in`  input  col*psum_bw: column j psum on bits [(j+1)*psum_bw-1 : j*psum_bw].
- `rd`  input  1: consumer pop request for one aligned row.
- `out`  output  col*psum_bw: head entry of every column, same packing as `in`. Meaningful only while `o_valid`=1.
- `o_valid`  output  1: every column FIFO is non-empty.
- `o_full`  output  1: at least one column FIFO is full.
- `o_ready`  output  1: equals `!o_full`. The array controller stalls execution while this is 0.
- `o_ovf`  output  1: sticky overflow flag.

## Operation
- Each column has a circular buffer with write and read pointers of log2(depth)+1 bits. The extra MSB disambiguates full from empty.
  - Empty: pointers equal.
  - Full: low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2·depth. Index is the low log2(depth) bits.
- Write, column j: if `wr[j]`=1 and column j is not full, store `in` slice j at wptr_j and increment wptr_j.
- Write to a full column: if no pop happens that cycle, data is dropped, wptr_j is unchanged, and `o_ovf` is set to 1.
- Pop: `rd`=1 and `o_valid`=1 increments every rptr in the same cycle. `rd` while `o_valid`=0 is ignored with no side effects.
- Simultaneous pop and write on a full column: the pop frees the slot, so the write is accepted and no overflow occurs. Occupancy stays at depth.
- Simultaneous pop and write on a column with one entry: both occur. The new word becomes head on the next cycle.
- `out` is combinational from storage at each rptr (FWFT). It is not reset-gated, so storage contents after reset are don't-care.
- `o_ovf` clears only on reset.
- No arithmetic is performed. Psums pass through bit-exact, signed or unsigned alike.

## Timing
- Reset values:
  - All pointers 0.
  - `o_valid`=0, `o_full`=0, `o_ready`=1, `o_ovf`=0.
- Write-to-visible latency is 1 cycle. A write at edge t makes the column non-empty after t, so `o_valid` can rise in the cycle following the last column's write.
- Pop latency is 0. `out` shows the next row in the cycle after the popping edge.
- Flags are derived combinationally from the registered pointers. No flag depends combinationally on `wr`, `rd` or `in`.
- Reset asserted mid-operation empties all columns immediately. Writes and reads in that cycle are lost. After release, operation resumes on the first rising edge.

## Structure
- Shared package holds:
  - the default parameters `col`, `psum_bw` and `depth`;
  - the pointer-width constant log2(depth)+1.
- One sub-module, `fifo_col`: a single-column FWFT FIFO with `wr`, `rd`, `in`, `out`, `empty`, `full`, and an overflow pulse.
- The top module generates `col` instances and derives:
  - `o_valid` as the AND of all `!empty`;
  - `o_full` as the OR of all `full`;
  - `o_ovf` as the sticky OR of the per-column overflow pulses.
- Every column instance receives the same `rd & o_valid`.

## Test plan
- Reset, then idle 5 cycles: `o_valid`=0, `o_full`=0, `o_ready`=1, `o_ovf`=0. Assert `reset`=0 between edges: flags return to reset values before the next edge.
- Skewed fill, col=8: column j writes value 0x0100+j at cycle j. `o_valid` stays 0 through cycle 7 and is 1 at cycle 8. `out` slice j = 0x0100+j. `rd` for one cycle then drops `o_valid` to 0.
- Fill column 0 with 16 writes (0x0000–0x000F): `o_full`=1 and `o_ready`=0. A 17th write (0xBEEF) sets `o_ovf`=1. Draining with all other columns fed returns 0x0000–0x000F in order, with no 0xBEEF.
- Column 0 full and all columns non-empty; assert `rd` and `wr[0]`=1 (0x1234) in the same cycle: `o_ovf` stays 0, column 0 stays full, and 0x1234 is read out last.
- `rd`=1 with column 3 empty and others holding data: no pointer moves and `out` for the other columns is unchanged. Then write column 3 = 0xFFFF (-1): `o_valid` rises next cycle and slice 3 reads 0xFFFF.
- Wrap: stream 40 aligned rows with concurrent `rd`, occupancy ≤ 3. All 40 rows are read in order with correct values across the pointer wrap, and `o_ovf`=0.

Source files
------------

// File: rtl/ofifo_align_pkg.sv
// Shared defaults and pointer sizing for the output-side column FIFO bank.
package ofifo_align_pkg;

   localparam int COL_DEF     = 8;
   localparam int PSUM_BW_DEF = 16;
   localparam int DEPTH_DEF   = 16;

   // Pointer width: index bits plus one wrap bit that separates full from empty.
   function automatic int ptr_width(input int d);
      return $clog2(d) + 1;
   endfunction

   localparam int PTR_W_DEF = ptr_width(DEPTH_DEF);

endpackage

// File: rtl/ofifo_align_fifo_col.sv
// Single-column first-word-fall-through FIFO with an overflow pulse.
module fifo_col
   import ofifo_align_pkg::*;
#(
   parameter int psum_bw = PSUM_BW_DEF,
   parameter int depth   = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr,
   input  logic               rd,
   input  logic [psum_bw-1:0] in,
   output logic [psum_bw-1:0] out,
   output logic               empty,
   output logic               full,
   output logic               ovf
);

   localparam int PW = ptr_width(depth);
   localparam int AW = PW - 1;

   logic [PW-1:0]      r_wptr;
   logic [PW-1:0]      r_rptr;
   logic [psum_bw-1:0] r_mem [depth];

   logic w_pop;
   logic w_push;

   assign empty  = (r_wptr == r_rptr);
   assign full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign w_pop  = rd && !empty;
   // A pop in the same cycle frees the slot, so a write to a full column is still accepted.
   assign w_push = wr && (!full || w_pop);
   assign ovf    = wr && full && !w_pop;

   // Head entry is presented straight from storage.
   assign out = r_mem[r_rptr[AW-1:0]];

   // Pointer update; wrap is natural modulo 2*depth.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage write; contents are don't-care after reset so no reset here.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= in;
   end

endmodule

// File: rtl/ofifo_align.sv
// Column FIFO bank that re-aligns skewed column psums into full rows.
module ofifo_align
   import ofifo_align_pkg::*;
#(
   parameter int col     = COL_DEF,
   parameter int psum_bw = PSUM_BW_DEF,
   parameter int depth   = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col-1:0]         wr,
   input  logic [col*psum_bw-1:0] in,
   input  logic                   rd,
   output logic [col*psum_bw-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_ovf
);

   logic [col-1:0] w_empty;
   logic [col-1:0] w_full;
   logic [col-1:0] w_ovf;
   logic           w_pop;
   logic           r_ovf;

   // A row pop is only honoured when every column has a head entry.
   assign w_pop   = rd && o_valid;
   assign o_valid = &(~w_empty);
   assign o_full  = |w_full;
   assign o_ready = !o_full;
   assign o_ovf   = r_ovf;

   generate
      for (genvar gi = 0; gi < col; gi++) begin : g_col
         fifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
         ) u_col (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[gi]),
            .rd    (w_pop),
            .in    (in[gi*psum_bw +: psum_bw]),
            .out   (out[gi*psum_bw +: psum_bw]),
            .empty (w_empty[gi]),
            .full  (w_full[gi]),
            .ovf   (w_ovf[gi])
         );
      end
   endgenerate

   // Sticky record of any dropped write; cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_ovf <= 1'b0;
      else if (|w_ovf) r_ovf <= 1'b1;
   end

endmodule

// File: tb/tb_ofifo_align.sv
// Randomised self-checking bench for ofifo_align against a queue-based model.
module tb_ofifo_align;

   localparam int COL = 8;
   localparam int PW  = 16;
   localparam int DEP = 16;

   logic                clk;
   logic                reset;
   logic [COL-1:0]      wr;
   logic [COL*PW-1:0]   in_d;
   logic                rd;
   logic [COL*PW-1:0]   out_d;
   logic                o_valid;
   logic                o_full;
   logic                o_ready;
   logic                o_ovf;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one queue per column plus the sticky overflow bit.
   logic [PW-1:0] mq [COL][$];
   logic          m_ovf;

   ofifo_align #(.col(COL), .psum_bw(PW), .depth(DEP)) dut (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr),
      .in      (in_d),
      .rd      (rd),
      .out     (out_d),
      .o_valid (o_valid),
      .o_full  (o_full),
      .o_ready (o_ready),
      .o_ovf   (o_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_valid();
      for (int j = 0; j < COL; j++) if (mq[j].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_full();
      for (int j = 0; j < COL; j++) if (mq[j].size() == DEP) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_clear();
      for (int j = 0; j < COL; j++) mq[j].delete();
      m_ovf = 1'b0;
   endtask

   // Compare every observable output with the model state.
   task automatic check_state(input string ctx);
      bit v, f;
      v = m_valid();
      f = m_full();
      chk({ctx, ".valid"}, o_valid, v);
      chk({ctx, ".full"},  o_full,  f);
      chk({ctx, ".ready"}, o_ready, !f);
      chk({ctx, ".ovf"},   o_ovf,   m_ovf);
      for (int j = 0; j < COL; j++) begin
         if (mq[j].size() > 0)
            chk($sformatf("%s.out%0d", ctx, j), out_d[j*PW +: PW], mq[j][0]);
      end
   endtask

   // Apply one edge to the model: row pop first, then per-column writes.
   task automatic m_step(input logic [COL-1:0] w, input logic [COL*PW-1:0] d, input logic r);
      bit pop;
      pop = r && m_valid();
      for (int j = 0; j < COL; j++) begin
         if (pop) void'(mq[j].pop_front());
         if (w[j]) begin
            if (mq[j].size() < DEP) mq[j].push_back(d[j*PW +: PW]);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic cycle(input string ctx, input logic [COL-1:0] w,
                        input logic [COL*PW-1:0] d, input logic r);
      @(negedge clk);
      check_state(ctx);
      $display("TXN %s wr=%02h rd=%0b valid=%0b full=%0b ovf=%0b", ctx, w, r, o_valid, o_full, o_ovf);
      wr   = w;
      in_d = d;
      rd   = r;
      @(posedge clk);
      m_step(w, d, r);
   endtask

   // Assert reset between edges and verify the flags clear without a clock edge.
   task automatic do_reset();
      @(negedge clk);
      wr = '0; rd = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst.valid", o_valid, 1'b0);
      chk("rst.full",  o_full,  1'b0);
      chk("rst.ready", o_ready, 1'b1);
      chk("rst.ovf",   o_ovf,   1'b0);
      m_clear();
      @(posedge clk);
      #2 reset = 1'b1;
   endtask

   function automatic logic [COL*PW-1:0] rand_row();
      logic [COL*PW-1:0] d;
      for (int j = 0; j < COL; j++) d[j*PW +: PW] = PW'($urandom);
      return d;
   endfunction

   initial begin
      logic [COL*PW-1:0] d;
      wr = '0; in_d = '0; rd = 1'b0;
      reset = 1'b0;
      m_clear();
      #12 reset = 1'b1;

      // Idle after reset.
      for (int i = 0; i < 5; i++) cycle("idle", '0, '0, 1'b0);

      // Skewed fill: column j writes at cycle j.
      for (int j = 0; j < COL; j++) begin
         d = '0;
         d[j*PW +: PW] = PW'(16'h0100 + j);
         cycle("skew", COL'(1) << j, d, 1'b0);
      end
      cycle("skew_pop", '0, '0, 1'b1);
      cycle("skew_after", '0, '0, 1'b0);

      // Fill column 0 to full, overflow with 0xBEEF, then drain with others fed.
      do_reset();
      for (int i = 0; i < DEP; i++) begin
         d = '0; d[0 +: PW] = PW'(i);
         cycle("fill0", COL'(1), d, 1'b0);
      end
      d = '0; d[0 +: PW] = 16'hBEEF;
      cycle("ovf0", COL'(1), d, 1'b0);
      for (int i = 0; i < DEP + 1; i++)
         cycle("drain0", ~COL'(1), rand_row(), 1'b1);
      cycle("drain0_end", '0, '0, 1'b0);

      // Full column 0 with concurrent pop and write: no overflow.
      do_reset();
      cycle("pw_all", '1, rand_row(), 1'b0);
      for (int i = 1; i < DEP; i++) cycle("pw_fill", COL'(1), rand_row(), 1'b0);
      d = rand_row(); d[0 +: PW] = 16'h1234;
      cycle("pw_both", COL'(1), d, 1'b1);
      for (int i = 0; i < DEP + 1; i++) cycle("pw_drain", ~COL'(1), rand_row(), 1'b1);
      cycle("pw_end", '0, '0, 1'b0);

      // Pop request while column 3 is empty is ignored.
      do_reset();
      cycle("c3_load", ~COL'(8), rand_row(), 1'b0);
      cycle("c3_rd", '0, '0, 1'b1);
      d = '0; d[3*PW +: PW] = 16'hFFFF;
      cycle("c3_wr", COL'(8), d, 1'b0);
      cycle("c3_pop", '0, '0, 1'b1);
      cycle("c3_end", '0, '0, 1'b0);

      // Stream 40 aligned rows across the pointer wrap.
      do_reset();
      for (int i = 0; i < 40; i++) cycle("wrap", '1, rand_row(), i > 0);
      cycle("wrap_last", '0, '0, 1'b1);
      cycle("wrap_end", '0, '0, 1'b0);

      // Random traffic including overflow and partial rows.
      do_reset();
      for (int i = 0; i < 300; i++)
         cycle("rand", COL'($urandom), rand_row(), 1'($urandom_range(0, 2) != 0));
      cycle("rand_end", '0, '0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
